dcache_resp_tcm: RTL



---
 rtl/dcache_resp_tcm.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dcache_resp_tcm.sv
// Bring-up data memory answering the LSU dcache port: single-outstanding loads and
// byte-masked stores through a write buffer. Optional ready stalls: DCACHE_RESP_RANDOM_STALL_EN.
//   state  | meaning
//   S_IDLE | ready for a load; also the response cycle of the previous load
//   S_WAIT | load accepted, latency counter running down
//   S_READ | array read and buffer merge, response data registered
module dcache_resp_tcm #(
    parameter int DEPTH        = 1024,
    parameter int LOAD_LATENCY = 2,
    parameter int WB_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] load_a_addr,
    input  logic        load_a_valid,
    output logic        load_a_ready,
    output logic [63:0] load_d_data,
    output logic        load_d_valid,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    input  logic        wvalid,
    output logic        wready
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WB_W  = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(LOAD_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               load_d_valid_q, load_d_valid_d;
    logic [63:0]        load_d_data_q, load_d_data_d;

    logic [IDX_W-1:0]   wb_idx_q  [WB_DEPTH];
    logic [63:0]        wb_data_q [WB_DEPTH];
    logic [7:0]         wb_mask_q [WB_DEPTH];
    logic [WB_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [WB_W:0]      count_q, count_d;

    logic [63:0]        mem_q [DEPTH];

    logic               stall, push, drain, accept, read_cycle;
    logic [IDX_W-1:0]   ld_idx, st_idx, rd_idx;
    logic [63:0]        merged;
    logic [WB_W-1:0]    slot;
    logic               unused_addr_bits;

`ifdef DCACHE_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = lfsr_q[0];

    always_ff @(posedge clk) begin
        if (!rstn) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign ld_idx           = load_a_addr[IDX_W+2:3];
    assign st_idx           = waddr[IDX_W+2:3];
    assign unused_addr_bits = ^{load_a_addr[63:IDX_W+3], load_a_addr[2:0],
                                waddr[63:IDX_W+3], waddr[2:0]};

    // Ready depends only on registered state, never on this cycle's drain.
    assign wready       = (count_q != (WB_W+1)'(WB_DEPTH)) && !stall;
    assign load_a_ready = (state_q == S_IDLE) && !stall;
    assign push         = wvalid && wready;
    assign accept       = load_a_valid && load_a_ready;
    assign read_cycle   = (state_q == S_READ) || ((LOAD_LATENCY == 1) && accept);
    assign rd_idx       = (state_q == S_READ) ? rd_idx_q : ld_idx;
    assign drain        = rstn && (count_q != '0) && !read_cycle;

    assign load_d_valid = load_d_valid_q;
    assign load_d_data  = load_d_data_q;

    // Oldest entry applied first so younger ones overwrite; same-cycle store last.
    always_comb begin
        merged = mem_q[rd_idx];
        slot   = head_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + WB_W'(i);
            if (((WB_W+1)'(i) < count_q) && (wb_idx_q[slot] == rd_idx)) begin
                for (int b = 0; b < 8; b++) begin
                    if (wb_mask_q[slot][b]) merged[8*b +: 8] = wb_data_q[slot][8*b +: 8];
                end
            end
        end
        if (push && (st_idx == rd_idx)) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_idx_d       = rd_idx_q;
        load_d_valid_d = 1'b0;
        load_d_data_d  = load_d_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_idx_d = ld_idx;
                    cnt_d    = CNT_W'(LOAD_LATENCY - 1);
                    if (LOAD_LATENCY == 1) begin
                        load_d_valid_d = 1'b1;
                        load_d_data_d  = merged;
                    end else if (LOAD_LATENCY == 2) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(2)) state_d = S_READ;
            end
            S_READ: begin
                cnt_d          = cnt_q - CNT_W'(1);
                load_d_valid_d = 1'b1;
                load_d_data_d  = merged;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d  = drain ? head_q + WB_W'(1) : head_q;
        tail_d  = push  ? tail_q + WB_W'(1) : tail_q;
        count_d = count_q + (WB_W+1)'(push) - (WB_W+1)'(drain);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rd_idx_q       <= '0;
            load_d_valid_q <= 1'b0;
            load_d_data_q  <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_idx_q       <= rd_idx_d;
            load_d_valid_q <= load_d_valid_d;
            load_d_data_q  <= load_d_data_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
        end
    end

    // Buffer payload and array carry no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_idx_q[tail_q]  <= st_idx;
            wb_data_q[tail_q] <= wdata;
            wb_mask_q[tail_q] <= wmask;
        end
        if (drain) begin
            for (int b = 0; b < 8; b++) begin
                if (wb_mask_q[head_q][b])
                    mem_q[wb_idx_q[head_q]][8*b +: 8] <= wb_data_q[head_q][8*b +: 8];
            end
        end
    end
endmodule
